// File: rtl/cache_arb_pkg.sv
// Shared types for the L1-to-memory arbiter: FSM state encoding and
// the owner tag used by the next-owner picker and the last_grant register.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  // A requester wants the bus whenever it asserts either strobe.
  function automatic logic is_requesting(input logic ren, input logic wen);
    return ren | wen;
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// Generic memory bus used between the L1 caches, the arbiter and memory.
// generic_bus is the slave-side view, cpu is the master-side view.
interface generic_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic                ren;
  logic                wen;
  logic                busy;
  logic [DATA_W/8-1:0] byte_en;

  modport generic_bus (
    input  addr, wdata, ren, wen, byte_en,
    output rdata, busy
  );

  modport cpu (
    output addr, wdata, ren, wen, byte_en,
    input  rdata, busy
  );

endinterface

// File: rtl/cache_arb_select.sv
// Combinational next-owner picker for the cache memory arbiter.
// Build option ARB_ROUND_ROBIN_EN: when defined, a tie goes to the requester
// not granted last; otherwise D$ always wins a tie.
module cache_arb_select
  import cache_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_t last_grant,
`endif
  input  logic       req_i,
  input  logic       req_d,
  output logic       pick_valid,
  output arb_owner_t pick_owner
);

  // Choose who gets the bus next; only meaningful while the FSM is idle.
  always_comb begin
    pick_valid = req_i | req_d;
    pick_owner = OWNER_D;
    if (req_i && !req_d) begin
      pick_owner = OWNER_I;
    end else if (req_i && req_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_owner = (last_grant == OWNER_I) ? OWNER_D : OWNER_I;
`else
      pick_owner = OWNER_D;
`endif
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-to-one arbiter serialising I$ and D$ memory traffic onto one bus.
// A grant is held until the transaction completes or is abandoned, and is
// always followed by one IDLE cycle. The non-granted side sees busy high.
// Build option ARB_ROUND_ROBIN_EN: adds a last_grant register so ties
// alternate; without it D$ has fixed priority.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  generic_bus_if.generic_bus     icache_gen_bus_if,
  generic_bus_if.generic_bus     dcache_gen_bus_if,
  generic_bus_if.cpu             mem_gen_bus_if,
  output logic                   grant_d,
  output logic                   grant_i
);

  arb_state_t state;
  logic       req_i;
  logic       req_d;
  logic       pick_valid;
  arb_owner_t pick_owner;

  assign req_i = is_requesting(icache_gen_bus_if.ren, icache_gen_bus_if.wen);
  assign req_d = is_requesting(dcache_gen_bus_if.ren, dcache_gen_bus_if.wen);

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_grant;

  // Remember who won the most recent arbitration so the next tie flips.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant <= OWNER_I;
    end else if (state == IDLE && pick_valid) begin
      last_grant <= pick_owner;
    end
  end
`endif

  cache_arb_select u_select (
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .req_i      (req_i),
    .req_d      (req_d),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  // Grant FSM with registered grant flags; every grant returns through IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      grant_i <= 1'b0;
      grant_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            if (pick_owner == OWNER_D) begin
              state   <= GRANT_D;
              grant_d <= 1'b1;
            end else begin
              state   <= GRANT_I;
              grant_i <= 1'b1;
            end
          end
        end
        GRANT_I: begin
          if (!req_i || !mem_gen_bus_if.busy) begin
            state   <= IDLE;
            grant_i <= 1'b0;
          end
        end
        GRANT_D: begin
          if (!req_d || !mem_gen_bus_if.busy) begin
            state   <= IDLE;
            grant_d <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_i <= 1'b0;
          grant_d <= 1'b0;
        end
      endcase
    end
  end

  // Route the owner's request downstream and the response back to it only.
  always_comb begin
    mem_gen_bus_if.addr       = {ADDR_W{1'b0}};
    mem_gen_bus_if.wdata      = {DATA_W{1'b0}};
    mem_gen_bus_if.byte_en    = {(DATA_W/8){1'b0}};
    mem_gen_bus_if.ren        = 1'b0;
    mem_gen_bus_if.wen        = 1'b0;
    icache_gen_bus_if.busy    = 1'b1;
    icache_gen_bus_if.rdata   = {DATA_W{1'b0}};
    dcache_gen_bus_if.busy    = 1'b1;
    dcache_gen_bus_if.rdata   = {DATA_W{1'b0}};
    case (state)
      GRANT_I: begin
        mem_gen_bus_if.addr     = icache_gen_bus_if.addr;
        mem_gen_bus_if.wdata    = icache_gen_bus_if.wdata;
        mem_gen_bus_if.byte_en  = icache_gen_bus_if.byte_en;
        mem_gen_bus_if.ren      = icache_gen_bus_if.ren;
        mem_gen_bus_if.wen      = icache_gen_bus_if.wen;
        icache_gen_bus_if.busy  = mem_gen_bus_if.busy;
        icache_gen_bus_if.rdata = mem_gen_bus_if.rdata;
      end
      GRANT_D: begin
        mem_gen_bus_if.addr     = dcache_gen_bus_if.addr;
        mem_gen_bus_if.wdata    = dcache_gen_bus_if.wdata;
        mem_gen_bus_if.byte_en  = dcache_gen_bus_if.byte_en;
        mem_gen_bus_if.ren      = dcache_gen_bus_if.ren;
        mem_gen_bus_if.wen      = dcache_gen_bus_if.wen;
        dcache_gen_bus_if.busy  = mem_gen_bus_if.busy;
        dcache_gen_bus_if.rdata = mem_gen_bus_if.rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed scenarios followed by a random
// phase, all outputs compared each cycle against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN for the tie-break rule.
module tb_cache_mem_arbiter;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic grant_i;
  logic grant_d;

  generic_bus_if #(.ADDR_W(32), .DATA_W(32)) ic_bus ();
  generic_bus_if #(.ADDR_W(32), .DATA_W(32)) dc_bus ();
  generic_bus_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .icache_gen_bus_if (ic_bus),
    .dcache_gen_bus_if (dc_bus),
    .mem_gen_bus_if    (mem_bus),
    .grant_d           (grant_d),
    .grant_i           (grant_i)
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Model: who owns the bus (0 none, 1 I$, 2 D$) and whether D$ won last.
  int model_owner = 0;
  bit model_last_d = 1'b0;

  int          cnt_gd;
  int          cnt_mren;
  logic        seen_dc_busy;
  logic [31:0] seen_dc_rdata;
  logic [31:0] seen_mem_addr;
  logic [31:0] seen_mem_wdata;
  logic [3:0]  seen_mem_be;
  logic        seen_mem_ren;
  logic        seen_grant_i;
  logic        seen_grant_d;
  string       grant_log;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic req_t mk_req(input logic ren, input logic wen,
                                  input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  input logic [3:0] be);
    req_t r;
    r.ren = ren;
    r.wen = wen;
    r.addr = addr;
    r.wdata = wdata;
    r.be = be;
    return r;
  endfunction

  function automatic req_t rand_req(input int pct);
    req_t r;
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(15));
    r.ren   = 1'b0;
    r.wen   = 1'b0;
    if ($urandom_range(99) < pct) begin
      case ($urandom_range(3))
        0: r.ren = 1'b1;
        1: r.wen = 1'b1;
        2: r.ren = 1'b1;
        default: begin r.ren = 1'b1; r.wen = 1'b1; end
      endcase
    end
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic applyStimulus(input logic rst_n, input req_t ic, input req_t dc,
                               input logic m_busy, input logic [31:0] m_rdata);
    req_t        exp_mem;
    logic        exp_ib;
    logic        exp_db;
    logic [31:0] exp_ir;
    logic [31:0] exp_dr;
    bit          ri;
    bit          rd;

    nRST           = rst_n;
    ic_bus.ren     = ic.ren;
    ic_bus.wen     = ic.wen;
    ic_bus.addr    = ic.addr;
    ic_bus.wdata   = ic.wdata;
    ic_bus.byte_en = ic.be;
    dc_bus.ren     = dc.ren;
    dc_bus.wen     = dc.wen;
    dc_bus.addr    = dc.addr;
    dc_bus.wdata   = dc.wdata;
    dc_bus.byte_en = dc.be;
    mem_bus.busy   = m_busy;
    mem_bus.rdata  = m_rdata;
    if (!rst_n) begin
      model_owner  = 0;
      model_last_d = 1'b0;
    end
    #1;

    exp_mem = '0;
    exp_ib  = 1'b1;
    exp_db  = 1'b1;
    exp_ir  = 32'h0;
    exp_dr  = 32'h0;
    if (model_owner == 1) begin
      exp_mem = ic;
      exp_ib  = m_busy;
      exp_ir  = m_rdata;
    end else if (model_owner == 2) begin
      exp_mem = dc;
      exp_db  = m_busy;
      exp_dr  = m_rdata;
    end

    checkOutput("grant_i",   grant_i,         (model_owner == 1) ? 32'd1 : 32'd0);
    checkOutput("grant_d",   grant_d,         (model_owner == 2) ? 32'd1 : 32'd0);
    checkOutput("mem_addr",  mem_bus.addr,    exp_mem.addr);
    checkOutput("mem_wdata", mem_bus.wdata,   exp_mem.wdata);
    checkOutput("mem_be",    mem_bus.byte_en, exp_mem.be);
    checkOutput("mem_ren",   mem_bus.ren,     exp_mem.ren);
    checkOutput("mem_wen",   mem_bus.wen,     exp_mem.wen);
    checkOutput("ic_busy",   ic_bus.busy,     exp_ib);
    checkOutput("ic_rdata",  ic_bus.rdata,    exp_ir);
    checkOutput("dc_busy",   dc_bus.busy,     exp_db);
    checkOutput("dc_rdata",  dc_bus.rdata,    exp_dr);

    if (grant_d === 1'b1) begin
      cnt_gd++;
      grant_log = {grant_log, "D"};
    end
    if (grant_i === 1'b1) grant_log = {grant_log, "I"};
    if (mem_bus.ren === 1'b1) cnt_mren++;
    seen_dc_busy   = dc_bus.busy;
    seen_dc_rdata  = dc_bus.rdata;
    seen_mem_addr  = mem_bus.addr;
    seen_mem_wdata = mem_bus.wdata;
    seen_mem_be    = mem_bus.byte_en;
    seen_mem_ren   = mem_bus.ren;
    seen_grant_i   = grant_i;
    seen_grant_d   = grant_d;

    @(posedge CLK);
    ri = ic.ren | ic.wen;
    rd = dc.ren | dc.wen;
    if (rst_n) begin
      if (model_owner == 0) begin
        if (ri && rd) begin
`ifdef ARB_ROUND_ROBIN_EN
          model_owner = model_last_d ? 1 : 2;
`else
          model_owner = 2;
`endif
        end else if (rd) begin
          model_owner = 2;
        end else if (ri) begin
          model_owner = 1;
        end
        if (model_owner != 0) model_last_d = (model_owner == 2);
      end else if (model_owner == 1) begin
        if (!ri || !m_busy) model_owner = 0;
      end else begin
        if (!rd || !m_busy) model_owner = 0;
      end
    end
    @(negedge CLK);
  endtask

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    req_t  quiet;
    req_t  d_rd;
    req_t  i_rd;
    req_t  d_wr;
    string exp_log;

    quiet = mk_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset held with both sides requesting: everything at reset values.
    applyStimulus(1'b0, rand_req(100), rand_req(100), 1'b1, 32'h1234_5678);
    applyStimulus(1'b0, rand_req(100), rand_req(100), 1'b0, 32'h8765_4321);

    // Simultaneous I$ read and D$ write straight out of reset.
    i_rd = mk_req(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    d_wr = mk_req(1'b0, 1'b1, 32'h0000_3000, 32'h5555_AAAA, 4'hF);
    applyStimulus(1'b1, i_rd, d_wr, 1'b0, 32'hAAAA_0001);
    applyStimulus(1'b1, i_rd, d_wr, 1'b0, 32'hAAAA_0002);
    checkOutput("tie_first_d", seen_grant_d, 32'd1);
    applyStimulus(1'b1, i_rd, quiet, 1'b0, 32'hAAAA_0003);
    applyStimulus(1'b1, i_rd, quiet, 1'b0, 32'hAAAA_0004);
    checkOutput("i_cycle4_addr", seen_mem_addr, 32'h0000_2000);
    checkOutput("i_cycle4_ren",  seen_mem_ren,  32'd1);
    applyStimulus(1'b1, quiet, quiet, 1'b0, 32'h0);

    // Single D$ read against a 3-cycle busy memory.
    cnt_gd = 0;
    cnt_mren = 0;
    d_rd = mk_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    applyStimulus(1'b1, quiet, d_rd, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, quiet, d_rd, 1'b1, 32'h0);
    applyStimulus(1'b1, quiet, d_rd, 1'b0, 32'hDEAD_BEEF);
    checkOutput("d_rd_busy_low", seen_dc_busy,  32'd0);
    checkOutput("d_rd_rdata",    seen_dc_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b1, quiet, quiet, 1'b1, 32'h0);
    checkOutput("d_rd_grant_cycles", cnt_gd,   32'd4);
    checkOutput("d_rd_ren_cycles",   cnt_mren, 32'd4);

    // Both requesting continuously for six zero-wait transactions.
    applyStimulus(1'b0, quiet, quiet, 1'b0, 32'h0);
    grant_log = "";
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, mk_req(1'b1, 1'b0, 32'h40 + k, 32'h0, 4'hF),
                    mk_req(1'b1, 1'b0, 32'h80 + k, 32'h0, 4'hF), 1'b0, $urandom);
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_log = "DIDIDI";
`else
    exp_log = "DDDDDD";
`endif
    checks++;
    assert (grant_log == exp_log) else begin
      failures++;
      $error("[TB] FAIL grant_order observed=%s expected=%s", grant_log, exp_log);
    end
    $display("[TB] grant order %s, model last_d=%0d", grant_log, model_last_d);
    applyStimulus(1'b1, quiet, quiet, 1'b0, 32'h0);

    // I$ abandons its request while memory is still busy; D$ is waiting.
    i_rd = mk_req(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    d_rd = mk_req(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    applyStimulus(1'b1, i_rd, quiet, 1'b1, 32'h0);
    applyStimulus(1'b1, i_rd, d_rd, 1'b1, 32'h0);
    applyStimulus(1'b1, quiet, d_rd, 1'b1, 32'h0);
    checkOutput("abandon_grant_i", seen_grant_i, 32'd1);
    checkOutput("abandon_mem_ren", seen_mem_ren, 32'd0);
    applyStimulus(1'b1, quiet, d_rd, 1'b1, 32'h0);
    applyStimulus(1'b1, quiet, d_rd, 1'b0, 32'h0BAD_F00D);
    checkOutput("after_abandon_grant_d", seen_grant_d, 32'd1);
    applyStimulus(1'b1, quiet, quiet, 1'b0, 32'h0);

    // Reset hits while D$ owns the bus and memory is busy.
    applyStimulus(1'b1, quiet, d_rd, 1'b1, 32'h0);
    applyStimulus(1'b1, quiet, d_rd, 1'b1, 32'h0);
    applyStimulus(1'b0, quiet, d_rd, 1'b1, 32'hFFFF_FFFF);
    checkOutput("reset_mid_grant_d", seen_grant_d, 32'd0);
    applyStimulus(1'b0, i_rd, d_rd, 1'b0, 32'hFFFF_FFFF);
    applyStimulus(1'b1, quiet, quiet, 1'b0, 32'h0);

    // D$ partial write: byte enables and data must pass through untouched.
    d_wr = mk_req(1'b0, 1'b1, 32'h0000_0700, 32'h0000_ABCD, 4'b0011);
    applyStimulus(1'b1, quiet, d_wr, 1'b1, 32'h0);
    applyStimulus(1'b1, quiet, d_wr, 1'b1, 32'h0);
    applyStimulus(1'b1, quiet, d_wr, 1'b1, 32'h0);
    applyStimulus(1'b1, quiet, d_wr, 1'b0, 32'h0);
    checkOutput("wr_be",    seen_mem_be,    32'h3);
    checkOutput("wr_wdata", seen_mem_wdata, 32'h0000_ABCD);
    applyStimulus(1'b1, quiet, quiet, 1'b0, 32'h0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(49) != 0), rand_req(55), rand_req(55),
                    ($urandom_range(99) < 60), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-to-one memory-side arbiter directly downstream of the split L1 caches. Takes the I$ and D$ memory-side generic buses and serializes them onto the single generic bus toward the bus controller or memory. Grants one requester at a time and holds the grant until that transaction completes. Hides all downstream traffic from the non-granted requester by holding its busy high.

## Interface
Parameters:
- ADDR_W, 32, address width of all three buses
- DATA_W, 32, data width of all three buses

Ports:
- CLK  input  1  system clock, all state on rising edge
- nRST  input  1  reset, asynchronous, active-low
- icache_gen_bus_if  generic_bus_if.generic_bus  bundle  I$ miss/fill requests (addr, wdata, ren, wen, byte_en in; rdata, busy out)
- dcache_gen_bus_if  generic_bus_if.generic_bus  bundle  D$ fill/writeback requests, same signal set
- mem_gen_bus_if  generic_bus_if.cpu  bundle  single downstream bus (addr, wdata, ren, wen, byte_en out; rdata, busy in)
- grant_d  output  1  registered: 1 while D$ owns the downstream bus (debug/perf)
- grant_i  output  1  registered: 1 while I$ owns the downstream bus

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D; state register reset to IDLE.
- IDLE:
  - Downstream addr/wdata/byte_en = 0, ren = wen = 0.
  - Both requesters see busy = 1, rdata = 0.
  - A requester is requesting when ren | wen.
  - Next state: GRANT_D if only D$ requests, GRANT_I if only I$ requests; tie resolved by priority (see Configuration); stay in IDLE if neither requests.
- GRANT_X:
  - X's addr, wdata, ren, wen, byte_en are passed combinationally to downstream.
  - X sees downstream busy and rdata directly; the other requester sees busy = 1, rdata = 0.
- Completion: in GRANT_X with (ren | wen) and downstream busy == 0. X observes busy low that cycle; next state IDLE.
- Abandon: in GRANT_X with X's ren and wen both 0 (e.g. I$ abort). Next state IDLE; downstream sees ren = wen = 0 that cycle.
- Mandatory IDLE cycle after every grant, so a requester still holding ren in its completion cycle is never re-granted.
- Requesters must hold addr, wdata, byte_en stable while busy is high; the arbiter does not latch them.
- ren and wen asserted together is passed through unchanged; the arbiter does not check it.
- grant_i / grant_d decode from the state register; never both 1.

## Timing
- Reset values: state IDLE; grant_i = grant_d = 0; downstream ren = wen = 0, addr = wdata = byte_en = 0; both requester busy = 1, rdata = 0; last_grant (if present) = I.
- Arbitration latency: a request seen in IDLE at cycle t drives the downstream bus at t+1.
- Zero-wait memory (busy low at t+1): completes at t+1, IDLE at t+2, earliest next grant at t+3.
- Peak throughput: one transaction per 2 cycles.
- N-cycle memory: grant held for exactly N+1 cycles of downstream busy (N high, 1 low).
- Reset asserted mid-grant: immediate return to IDLE. The in-flight downstream transaction is dropped; no response is forwarded.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A 1-bit last_grant register is updated on entry to GRANT_I/GRANT_D.
  - A tie grants the requester not granted last; reset value I means D$ wins the first tie.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, D$ always wins ties.
  - No last_grant register.

## Structure
- arb_state_t enum (IDLE, GRANT_I, GRANT_D) and arb_owner_t (OWNER_I, OWNER_D) go in shared package cache_arb_pkg.
- One sub-module, cache_arb_select: combinational next-owner picker taking the two request bits and last_grant. It holds the ARB_ROUND_ROBIN_EN ifdef so the FSM stays identical in both builds.

## Test plan
- Single D$ read at addr 0x100, memory 3-cycle busy, rdata 0xDEADBEEF: downstream ren high for 4 cycles, D$ sees busy low with 0xDEADBEEF on the 4th; I$ busy stays 1; grant_d 1 for 4 cycles.
- Simultaneous I$ read 0x2000 and D$ write 0x3000 from reset, zero-wait memory: D$ served first (both builds); I$ downstream at cycle 4.
- ARB_ROUND_ROBIN_EN, both requesting continuously for 6 transactions: grants alternate D, I, D, I, D, I. Without the macro: I$ starved while D$ keeps requesting.
- I$ granted, I$ drops ren after 1 cycle with memory still busy: next cycle IDLE, downstream ren = 0, pending D$ request granted the cycle after.
- nRST asserted during a GRANT_D with memory busy: all outputs at reset values in the same cycle; FSM stays IDLE until nRST deasserts.
- D$ write with byte_en 4'b0011, wdata 0x0000ABCD: identical values seen on the downstream bus throughout the grant.
